// File: rtl/brick_pkg.sv
// Shared types and colour constants for the brick colour mapper and its hit tracker.
package brick_pkg;
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         color;
    logic               alive;
  } brick_t;

  // Entry 0 is the rightmost element of the concatenation.
  localparam logic [3:0][23:0] BRICK_PALETTE = {24'hC0C040, 24'h4040C0, 24'h40C040, 24'hC04040};
  localparam logic [23:0]      BALL_RGB      = 24'h00FFFF;
  localparam logic [7:0]       BG_BLUE       = 8'h44;
endpackage

// File: rtl/brick_hit_tracker.sv
// Collects ball/brick overlaps per frame, publishes them at frame_start and hands
// struck brick indices to game logic one at a time over valid/ready.
module brick_hit_tracker #(
  parameter int N_BRICKS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_frame_start,
  input  logic [N_BRICKS-1:0] i_overlap,
  input  logic                i_hit_ready,
  output logic                o_hit_valid,
  output logic [IDX_W-1:0]    o_hit_idx,
  output logic [N_BRICKS-1:0] o_clr
);
  logic [N_BRICKS-1:0] r_pending;
  logic [N_BRICKS-1:0] r_report;
  logic                r_hit_valid;
  logic [IDX_W-1:0]    r_hit_idx;
  logic [N_BRICKS-1:0] w_remain;
  logic                w_accept;

  function automatic logic [IDX_W-1:0] f_lowest(input logic [N_BRICKS-1:0] v);
    f_lowest = '0;
    for (int i = N_BRICKS - 1; i >= 0; i--)
      if (v[i]) f_lowest = IDX_W'(i);
  endfunction

  assign w_accept = r_hit_valid && i_hit_ready;
  assign o_clr    = w_accept ? (N_BRICKS'(1) << r_hit_idx) : '0;
  assign w_remain = r_report & ~o_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_report    <= '0;
      r_hit_valid <= 1'b0;
      r_hit_idx   <= '0;
    end else begin
      if (i_frame_start) begin
        r_report  <= w_remain | r_pending;
        r_pending <= i_overlap;
      end else begin
        r_report  <= w_remain;
        r_pending <= r_pending | i_overlap;
      end
      // Freeze the offered index until it is taken so new frames cannot reorder it.
      if (!(r_hit_valid && !i_hit_ready)) begin
        r_hit_valid <= |w_remain;
        r_hit_idx   <= f_lowest(w_remain);
      end
    end
  end

  assign o_hit_valid = r_hit_valid;
  assign o_hit_idx   = r_hit_idx;
endmodule

// File: rtl/brick_color_mapper.sv
// Two-stage pixel colour pipeline for ball, bricks and background with a writable brick table.
// Define BRICK_GRADIENT_BG_EN for a DrawX-dependent red background gradient.
module brick_color_mapper
  import brick_pkg::*;
#(
  parameter int N_BRICKS = 16,
  parameter int BRICK_W  = 40,
  parameter int BRICK_H  = 16,
  parameter int IDX_W    = (N_BRICKS > 1) ? $clog2(N_BRICKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  input  logic [COORD_W-1:0]  BallX,
  input  logic [COORD_W-1:0]  BallY,
  input  logic [COORD_W-1:0]  Ball_size,
  input  logic                frame_start,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [COORD_W-1:0]  wr_x,
  input  logic [COORD_W-1:0]  wr_y,
  input  logic [1:0]          wr_color,
  input  logic                wr_alive,
  output logic                hit_valid,
  output logic [IDX_W-1:0]    hit_idx,
  input  logic                hit_ready,
  output logic [N_BRICKS-1:0] alive,
  output logic [7:0]          Red,
  output logic [7:0]          Green,
  output logic [7:0]          Blue
);
  brick_t              r_tbl [N_BRICKS];
  logic [N_BRICKS-1:0] w_clr;
  logic [N_BRICKS-1:0] w_hit;
  logic [1:0]          w_sel_color;
  logic signed [10:0]  w_dx, w_dy;
  logic signed [21:0]  w_dxe, w_dye;
  logic [21:0]         w_dist2, w_r2;
  logic                w_ball_on;
  logic                r_ball_p1;
  logic                r_any_p1;
  logic [1:0]          r_color_p1;
  logic [N_BRICKS-1:0] r_hit_p1;
  logic [23:0]         w_bg;

  always_ff @(posedge Clk) begin
    for (int i = 0; i < N_BRICKS; i++) begin
      if (Reset)
        r_tbl[i] <= '0;
      else if (wr_en && wr_idx == IDX_W'(i))
        r_tbl[i] <= '{x: wr_x, y: wr_y, color: wr_color, alive: wr_alive};
      else if (w_clr[i])
        r_tbl[i].alive <= 1'b0;
    end
  end

  always_comb begin
    alive = '0;
    for (int i = 0; i < N_BRICKS; i++) alive[i] = r_tbl[i].alive;
  end

  assign w_dx      = $signed({1'b0, DrawX}) - $signed({1'b0, BallX});
  assign w_dy      = $signed({1'b0, DrawY}) - $signed({1'b0, BallY});
  assign w_dxe     = 22'(w_dx);
  assign w_dye     = 22'(w_dy);
  assign w_dist2   = $unsigned(w_dxe * w_dxe) + $unsigned(w_dye * w_dye);
  assign w_r2      = 22'(Ball_size) * 22'(Ball_size);
  assign w_ball_on = (w_dist2 <= w_r2);

  // Bounds computed in 11 bits so a brick near x=1023 does not wrap to the left edge.
  always_comb begin
    w_hit       = '0;
    w_sel_color = '0;
    for (int i = 0; i < N_BRICKS; i++) begin
      w_hit[i] = r_tbl[i].alive
              && (DrawX >= r_tbl[i].x)
              && ({1'b0, DrawX} < ({1'b0, r_tbl[i].x} + 11'(BRICK_W)))
              && (DrawY >= r_tbl[i].y)
              && ({1'b0, DrawY} < ({1'b0, r_tbl[i].y} + 11'(BRICK_H)));
    end
    for (int i = N_BRICKS - 1; i >= 0; i--)
      if (w_hit[i]) w_sel_color = r_tbl[i].color;
  end

  // Stage 1 boundary: geometry results
`ifdef BRICK_GRADIENT_BG_EN
  logic [6:0] r_gx_p1;
  always_ff @(posedge Clk) begin
    if (Reset) r_gx_p1 <= '0;
    else       r_gx_p1 <= DrawX[9:3];
  end
  assign w_bg = {8'h4F - {1'b0, r_gx_p1}, 8'h00, BG_BLUE};
`else
  assign w_bg = {16'h0000, BG_BLUE};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ball_p1  <= 1'b0;
      r_any_p1   <= 1'b0;
      r_color_p1 <= '0;
      r_hit_p1   <= '0;
    end else begin
      r_ball_p1  <= w_ball_on;
      r_any_p1   <= |w_hit;
      r_color_p1 <= w_sel_color;
      r_hit_p1   <= w_hit;
    end
  end

  // Stage 2 boundary: final colour
  always_ff @(posedge Clk) begin
    if (Reset)
      {Red, Green, Blue} <= '0;
    else if (r_ball_p1)
      {Red, Green, Blue} <= BALL_RGB;
    else if (r_any_p1)
      {Red, Green, Blue} <= BRICK_PALETTE[r_color_p1];
    else
      {Red, Green, Blue} <= w_bg;
  end

  brick_hit_tracker #(.N_BRICKS(N_BRICKS), .IDX_W(IDX_W)) u_tracker (
    .clk          (Clk),
    .rst          (Reset),
    .i_frame_start(frame_start),
    .i_overlap    ({N_BRICKS{r_ball_p1}} & r_hit_p1),
    .i_hit_ready  (hit_ready),
    .o_hit_valid  (hit_valid),
    .o_hit_idx    (hit_idx),
    .o_clr        (w_clr)
  );
endmodule

// File: tb/tb_brick_color_mapper.sv
// Self-checking bench for brick_color_mapper: pixel colours via a latency-tagged scoreboard,
// hit reporting via hand-written handshake sequences.
module tb_brick_color_mapper;
  localparam int N = 16;
  localparam logic [23:0] PAL0 = 24'hC04040;
  localparam logic [23:0] PAL1 = 24'h40C040;
  localparam logic [23:0] PAL2 = 24'h4040C0;
  localparam logic [23:0] PAL3 = 24'hC0C040;
  localparam logic [23:0] BALL = 24'h00FFFF;

  logic clk = 1'b0;
  logic rst;
  logic [9:0] dx, dy, bx, by, bs;
  logic fs, wen, wal, hrdy;
  logic [3:0] widx;
  logic [9:0] wx, wy;
  logic [1:0] wcol;
  logic hv;
  logic [3:0] hidx;
  logic [N-1:0] alv;
  logic [7:0] r, g, b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int due; logic [23:0] rgb; int id; } sb_t;
  sb_t sbq[$];

  typedef struct { logic [9:0] x, y, bx, by, bs; logic [23:0] rgb; } vec_t;
  vec_t vecs[$];

  brick_color_mapper #(.N_BRICKS(N), .BRICK_W(40), .BRICK_H(16)) dut (
    .Clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy), .BallX(bx), .BallY(by),
    .Ball_size(bs), .frame_start(fs), .wr_en(wen), .wr_idx(widx), .wr_x(wx),
    .wr_y(wy), .wr_color(wcol), .wr_alive(wal), .hit_valid(hv), .hit_idx(hidx),
    .hit_ready(hrdy), .alive(alv), .Red(r), .Green(g), .Blue(b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] bg(input logic [9:0] x);
`ifdef BRICK_GRADIENT_BG_EN
    logic [7:0] red;
    red = 8'h4F - {1'b0, x[9:3]};
    return {red, 8'h00, 8'h44};
`else
    return {x[0] & 1'b0, 23'h000044};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_t e;
      e = sbq.pop_front();
      chk($sformatf("rgb#%0d", e.id), {8'h00, r, g, b}, {8'h00, e.rgb});
    end
  end

  int px_id = 0;
  task automatic px(input logic [9:0] x, y, ballx, bally, size, input logic check, input logic [23:0] exp);
    dx = x; dy = y; bx = ballx; by = bally; bs = size;
    if (check) begin
      sbq.push_back('{cyc + 2, exp, px_id});
      px_id++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) px(10'd600, 10'd600, 10'd1023, 10'd1023, 10'd0, 1'b0, 24'h0);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [9:0] x, y, input logic [1:0] c, input logic a);
    wen = 1'b1; widx = idx; wx = x; wy = y; wcol = c; wal = a;
    idle(1);
    wen = 1'b0;
  endtask

  task automatic frame_pulse();
    fs = 1'b1;
    idle(1);
    fs = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fs = 0; wen = 0; wal = 0; hrdy = 0; widx = 0; wx = 0; wy = 0; wcol = 0;
    dx = 0; dy = 0; bx = 10'd1023; by = 10'd1023; bs = 0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {8'h00, r, g, b}, 32'h0);
    chk("rst_hv", {31'h0, hv}, 32'h0);
    chk("rst_alive", {16'h0, alv}, 32'h0);
    rst = 1'b0;

    px(10'd100, 10'd100, 10'd1023, 10'd1023, 10'd0, 1'b1, bg(10'd100));
    wr(4'd3, 10'd200, 10'd50, 2'd1, 1'b1);
    chk("alive3_set", {16'h0, alv}, 32'h0008);

    vecs.push_back('{10'd239, 10'd65, 10'd1023, 10'd1023, 10'd0, PAL1});
    vecs.push_back('{10'd240, 10'd65, 10'd1023, 10'd1023, 10'd0, bg(10'd240)});
    vecs.push_back('{10'd200, 10'd50, 10'd1023, 10'd1023, 10'd0, PAL1});
    vecs.push_back('{10'd199, 10'd50, 10'd1023, 10'd1023, 10'd0, bg(10'd199)});
    vecs.push_back('{10'd220, 10'd66, 10'd1023, 10'd1023, 10'd0, bg(10'd220)});
    vecs.push_back('{10'd220, 10'd49, 10'd1023, 10'd1023, 10'd0, bg(10'd220)});
    vecs.push_back('{10'd505, 10'd305, 10'd500, 10'd300, 10'd10, BALL});
    vecs.push_back('{10'd510, 10'd300, 10'd500, 10'd300, 10'd10, BALL});
    vecs.push_back('{10'd510, 10'd301, 10'd500, 10'd300, 10'd10, bg(10'd510)});
    vecs.push_back('{10'd0,   10'd0,   10'd5,   10'd0,   10'd4,  bg(10'd0)});
    for (int i = 0; i < vecs.size(); i++)
      px(vecs[i].x, vecs[i].y, vecs[i].bx, vecs[i].by, vecs[i].bs, 1'b1, vecs[i].rgb);
    idle(3);
    chk("no_hit_yet", {31'h0, hv}, 32'h0);

    // Single strike on slot 3, ball drawn over brick.
    px(10'd220, 10'd58, 10'd220, 10'd58, 10'd5, 1'b1, BALL);
    px(10'd224, 10'd58, 10'd220, 10'd58, 10'd5, 1'b1, BALL);
    idle(3);
    chk("hv_before_fs", {31'h0, hv}, 32'h0);
    frame_pulse();
    chk("hv_1cyc", {31'h0, hv}, 32'h0);
    idle(1);
    chk("hv_2cyc", {31'h0, hv}, 32'h1);
    chk("hidx_3", {28'h0, hidx}, 32'd3);
    hrdy = 1'b1;
    idle(1);
    hrdy = 1'b0;
    chk("hv_after_acc", {31'h0, hv}, 32'h0);
    chk("alive3_clr", {16'h0, alv}, 32'h0);
    px(10'd239, 10'd65, 10'd1023, 10'd1023, 10'd0, 1'b1, bg(10'd239));
    idle(3);

    // Two strikes in one frame, held then accepted in order.
    wr(4'd2, 10'd100, 10'd200, 2'd2, 1'b1);
    wr(4'd5, 10'd300, 10'd200, 2'd3, 1'b1);
    px(10'd100, 10'd200, 10'd1023, 10'd1023, 10'd0, 1'b1, PAL2);
    px(10'd339, 10'd215, 10'd1023, 10'd1023, 10'd0, 1'b1, PAL3);
    px(10'd310, 10'd205, 10'd310, 10'd205, 10'd3, 1'b1, BALL);
    px(10'd110, 10'd205, 10'd110, 10'd205, 10'd3, 1'b1, BALL);
    idle(3);
    frame_pulse();
    idle(1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold_hv%0d", k), {31'h0, hv}, 32'h1);
      chk($sformatf("hold_idx%0d", k), {28'h0, hidx}, 32'd2);
      idle(1);
    end
    hrdy = 1'b1;
    idle(1);
    hrdy = 1'b0;
    chk("second_hv", {31'h0, hv}, 32'h1);
    chk("second_idx", {28'h0, hidx}, 32'd5);
    hrdy = 1'b1;
    idle(1);
    hrdy = 1'b0;
    chk("drained_hv", {31'h0, hv}, 32'h0);
    chk("alive_2_5_clr", {16'h0, alv}, 32'h0);

    // Write and acceptance of the same slot in the same cycle.
    wr(4'd2, 10'd100, 10'd200, 2'd2, 1'b1);
    px(10'd110, 10'd205, 10'd110, 10'd205, 10'd3, 1'b1, BALL);
    idle(3);
    frame_pulse();
    idle(1);
    chk("wa_hv", {31'h0, hv}, 32'h1);
    chk("wa_idx", {28'h0, hidx}, 32'd2);
    wen = 1'b1; widx = 4'd2; wx = 10'd100; wy = 10'd200; wcol = 2'd2; wal = 1'b1; hrdy = 1'b1;
    idle(1);
    wen = 1'b0; hrdy = 1'b0;
    chk("wa_alive2", {16'h0, alv}, 32'h0004);
    idle(1);
    chk("wa_hv_clr", {31'h0, hv}, 32'h0);
    px(10'd139, 10'd215, 10'd1023, 10'd1023, 10'd0, 1'b1, PAL2);

    // Brick at the right edge, then reset mid-handshake.
    wr(4'd7, 10'd1000, 10'd400, 2'd0, 1'b1);
    px(10'd1023, 10'd405, 10'd1023, 10'd1023, 10'd0, 1'b1, PAL0);
    px(10'd5,    10'd405, 10'd1023, 10'd1023, 10'd0, 1'b1, bg(10'd5));
    px(10'd1000, 10'd415, 10'd1023, 10'd1023, 10'd0, 1'b1, PAL0);
    px(10'd999,  10'd405, 10'd1023, 10'd1023, 10'd0, 1'b1, bg(10'd999));
    px(10'd1010, 10'd405, 10'd1010, 10'd405, 10'd2, 1'b1, BALL);
    idle(3);
    frame_pulse();
    idle(1);
    chk("edge_hv", {31'h0, hv}, 32'h1);
    chk("edge_idx", {28'h0, hidx}, 32'd7);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_hv", {31'h0, hv}, 32'h0);
    chk("mid_rst_alive", {16'h0, alv}, 32'h0);
    chk("mid_rst_rgb", {8'h00, r, g, b}, 32'h0);
    rst = 1'b0;
    px(10'd1023, 10'd405, 10'd1023, 10'd1023, 10'd0, 1'b1, bg(10'd1023));
    idle(4);
    chk("post_rst_hv", {31'h0, hv}, 32'h0);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/brick_color_mapper.md
# brick_color_mapper

Pixel-pipelined colour mapper for the ball-and-brick playfield, placed between the VGA controller and the DAC outputs. It holds a writable table of up to N_BRICKS rectangular bricks with alive bits and palette indices, and draws ball, bricks and background with a fixed 2-cycle latency. It also detects ball/brick pixel overlap during each frame and reports each struck brick to game logic over a valid/ready handshake, clearing that brick's alive bit on acceptance.

## Interface
- N_BRICKS, 16, number of brick slots (1..32)
- BRICK_W, 40, brick width in pixels (shared by all bricks)
- BRICK_H, 16, brick height in pixels
- IDX_W, $clog2(N_BRICKS) (min 1), brick index width
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- DrawX, DrawY  in  10 each  current pixel coordinate from VGA controller
- BallX, BallY, Ball_size  in  10 each  ball centre and radius; sampled per pixel
- frame_start  in  1  one-cycle pulse at start of vertical blank
- wr_en  in  1  brick table write strobe
- wr_idx  in  IDX_W  slot being written
- wr_x, wr_y  in  10 each  brick top-left corner
- wr_color  in  2  palette index
- wr_alive  in  1  alive bit to store
- hit_valid  out  1  struck brick report pending
- hit_idx  out  IDX_W  index of reported brick
- hit_ready  in  1  game logic accepts report
- alive  out  N_BRICKS  current alive bits
- Red, Green, Blue  out  8 each  pixel colour

## Operation
- Stage 1 (registered): DistX/DistY as signed 11-bit DrawX−BallX, DrawY−BallY; ball_on = DistX²+DistY² ≤ Ball_size², all in 22-bit unsigned; per-slot brick_hit[i] = alive[i] && x_i ≤ DrawX < x_i+BRICK_W && y_i ≤ DrawY < y_i+BRICK_H, sums in 11 bits (no wrap at 1023).
- Stage 2 (registered): priority ball > lowest-index brick_hit > background. Ball colour 00/FF/FF. Brick colour = palette[color_i]. Background per Configuration.
- Overlap: in stage 2, if ball_on and brick_hit[i], set pending[i].
- frame_start: report |= pending; pending cleared same cycle (pixel overlaps in that same cycle land in the new pending).
- Report: hit_valid = |report; hit_idx = lowest set index of report (registered, updates the cycle after report changes).
- hit_valid && hit_ready: clear report[hit_idx] and alive[hit_idx]; next lowest index presented the following cycle. hit_idx and hit_valid stable while hit_valid && !hit_ready.
- wr_en: slot wr_idx takes x, y, color, alive at next edge; wr_idx ≥ N_BRICKS ignored. Write and hit-acceptance to same slot in same cycle: write wins for alive; report bit still cleared.
- Reset: alive, pending, report all 0; table x/y/color 0; hit_valid 0, hit_idx 0; Red/Green/Blue 0; pipeline registers 0.

## Timing
- Pixel latency exactly 2 cycles: DrawX/DrawY at edge t produce RGB after edge t+2; one pixel per cycle throughput, no stalls.
- Table writes visible to stage 1 the cycle after wr_en.
- First hit_valid no earlier than 2 cycles after frame_start (report update, then hit_idx register).
- Reset mid-frame or mid-handshake: all state cleared next edge; an unaccepted report is discarded.

## Configuration
- BRICK_GRADIENT_BG_EN defined: background Red = 8'h4F − DrawX[9:3] (8-bit wrap), Green 00, Blue 44.
- Undefined: flat background 00/00/44; no DrawX subtraction logic generated.

## Structure
- Package brick_pkg: brick_t struct {x, y, color, alive}, 4-entry 24-bit palette constant BRICK_PALETTE, BALL_RGB and BG_BLUE constants, COORD_W = 10.
- One sub-module: brick_hit_tracker (pending/report registers, priority encoder, valid/ready handshake, alive clears); top holds table and pixel pipeline.

## Test plan
- Reset then DrawX=100, DrawY=100, no bricks -> RGB 00/00/44 after 2 cycles (4F−0C=43 red if gradient enabled).
- Write slot 3 x=200,y=50,color=1,alive=1; draw (239,65) -> palette[1]; draw (240,65) -> background (right edge exclusive).
- Ball at (220,58) radius 5 over slot 3; sweep frame; frame_start -> hit_valid=1, hit_idx=3 two cycles later; hit_ready=1 -> alive[3]=0, hit_valid=0 next cycle, brick no longer drawn.
- Slots 2 and 5 both struck in one frame; hit_ready held low 10 cycles -> hit_idx stays 2; accept -> idx 5 next cycle; accept -> hit_valid 0.
- wr_en to slot 2 with wr_alive=1 same cycle as acceptance of slot 2 -> alive[2]=1, report[2] cleared.
- Brick at x=1000 (x+BRICK_W=1040): draw (1023,y in range) -> brick colour, no wrap to x=0..15; Reset asserted with hit_valid=1 -> hit_valid 0, alive 0 next edge.
